// File: rtl/rr_arb_mux.sv
// rr_arb_mux: CH-channel round-robin valid/ready arbiter with registered output.
// Optional packet locking via macro RR_ARB_MUX_LOCK_EN (adds in_last/out_last).
module rr_arb_mux #(
  parameter int N    = 32,
  parameter int CH   = 2,
  parameter int SELW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*N-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [CH-1:0]   in_last,
  output logic            out_last,
`endif
  output logic [CH-1:0]   in_ready,
  output logic [N-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_sel
);

  logic [SELW-1:0] r_ptr;
  logic [N-1:0]    r_data;
  logic            r_valid;
  logic [SELW-1:0] r_sel;

  logic            w_load;
  logic [CH-1:0]   w_req;
  logic [CH-1:0]   w_grant;
  logic            w_any;
  logic [SELW-1:0] w_gidx;
  logic [N-1:0]    w_gdata;

  assign w_load = ~rst & (~r_valid | out_ready);

`ifdef RR_ARB_MUX_LOCK_EN
  logic            r_lock;
  logic [SELW-1:0] r_lock_ch;
  logic            r_last;
  logic [CH-1:0]   w_lock_mask;
  logic            w_glast;

  // While a burst is open only the locked channel may request
  always_comb begin
    w_lock_mask = '0;
    for (int i = 0; i < CH; i++) begin
      w_lock_mask[i] = (SELW'(i) == r_lock_ch);
    end
    w_req = r_lock ? (in_valid & w_lock_mask) : in_valid;
  end

  // Pick the in_last bit of the granted channel
  always_comb begin
    w_glast = 1'b1;
    for (int i = 0; i < CH; i++) begin
      if (w_grant[i]) w_glast = in_last[i];
    end
  end

  // Lock tracks open bursts; out_last travels with out_data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
      r_last    <= 1'b0;
    end else if (w_load && w_any) begin
      r_lock    <= ~w_glast;
      r_lock_ch <= w_gidx;
      r_last    <= w_glast;
    end
  end

  assign out_last = r_last;
`else
  assign w_req = in_valid;
`endif

  // Rotating search starting just after the last granted channel
  always_comb begin
    int j;
    j       = 0;
    w_any   = 1'b0;
    w_gidx  = '0;
    w_gdata = '0;
    w_grant = '0;
    for (int k = 1; k <= CH; k++) begin
      j = int'(r_ptr) + k;
      if (j >= CH) j = j - CH;
      if (!w_any && w_req[j]) begin
        w_any      = 1'b1;
        w_gidx     = SELW'(j);
        w_gdata    = in_data[j*N +: N];
        w_grant[j] = 1'b1;
      end
    end
  end

  assign in_ready = w_grant & {CH{w_load}};

  // Output register and priority pointer advance only on a load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= SELW'(CH - 1);
    end else if (w_load) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= w_gdata;
        r_sel   <= w_gidx;
        r_ptr   <= w_gidx;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_sel   = r_sel;

endmodule
